// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_pkg
// Description : Shared types and constants for the stage-4 branch resolver:
//               word type, compare-flag indices, instruction class bits and
//               default squash depth.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Indices into the ALU compare flag vector (signed compares only)
    localparam int CMP_EQ = 0;
    localparam int CMP_NE = 1;
    localparam int CMP_LT = 2;
    localparam int CMP_GE = 3;

    // One-hot instruction class vector
    localparam int INSTR_W   = 6;
    localparam int DO_ALU    = 0;
    localparam int DO_LOAD   = 1;
    localparam int DO_STORE  = 2;
    localparam int DO_BRANCH = 3;
    localparam int DO_JAL    = 4;
    localparam int DO_JALR   = 5;

    // Younger in-flight instructions (stages 1-3) to drop after a redirect
    localparam int FLUSH_DEPTH_DEFAULT = 3;
    localparam int CNT_W_DEFAULT       = 2;

    // Sequential fetch address; wraps naturally at 2^32
    function automatic word_t seq_pc(input word_t pc);
        return pc + word_t'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_squash_counter.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_squash_counter
// Description : Wrong-path squash counter. Loads FLUSH_DEPTH on a redirect,
//               counts down once per real instruction dropped, holds on stall.
//               busy is high while any wrong-path instruction remains.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_squash_counter
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    input  logic load,
    input  logic dec,
    output logic busy
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: reload wins over decrement; never wrap below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(FLUSH_DEPTH);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register: reset clears even mid-squash, stall freezes
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!stall) begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Stage-4 branch/jump resolution. Registers the ALU result,
//               compares the actual control flow against the fetch
//               prediction, pulses a redirect on mismatch and squashes the
//               wrong-path instructions that follow it.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               valid_in,
    input  logic [INSTR_W-1:0] instr_type,
    input  logic [1:0]         cond_sel,
    input  logic               predict_taken,
    input  word_t              pc,
    input  word_t              imm,
    input  logic [3:0]         compare_async,
    input  word_t              eval_async,
    output logic               valid_out,
    output word_t              result,
    output logic               redirect_valid,
    output word_t              redirect_pc,
    output logic               squashing
);

    logic  busy;
    logic  live;
    logic  is_branch;
    logic  is_jal;
    logic  is_jalr;
    logic  taken;
    logic  mispredict;
    word_t link_pc;
    word_t target;
    word_t actual_next;

    logic  valid_out_d;
    logic  valid_out_q;
    word_t result_d;
    word_t result_q;
    logic  redirect_valid_d;
    logic  redirect_valid_q;
    word_t redirect_pc_d;
    word_t redirect_pc_q;

    // Non-control-flow class bits carry no meaning for this stage
    logic  unused_class_bits;
    assign unused_class_bits = ^instr_type[DO_STORE:DO_ALU];

    // Resolve actual control flow and compute next register values
    always_comb begin
        is_branch = instr_type[DO_BRANCH];
        is_jal    = instr_type[DO_JAL];
        is_jalr   = instr_type[DO_JALR];

        // An instruction arriving while the counter is non-zero is wrong-path
        live = valid_in & ~busy;

        taken = 1'b0;
        if (is_branch) begin
            taken = compare_async[cond_sel];
        end
        if (is_jal || is_jalr) begin
            taken = 1'b1;
        end

        link_pc     = seq_pc(pc);
        target      = is_jalr ? {eval_async[WORD_W-1:1], 1'b0} : (pc + imm);
        actual_next = taken ? target : link_pc;

        // Only direction is compared: a correctly predicted taken branch
        // already has its target in fetch
        mispredict = live & (taken != predict_taken);

        valid_out_d      = live;
        result_d         = (is_jal || is_jalr) ? link_pc : eval_async;
        redirect_valid_d = mispredict;
        redirect_pc_d    = mispredict ? actual_next : redirect_pc_q;
    end

    // Output registers: one-cycle latency, frozen by stall
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out_q      <= 1'b0;
            result_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (!stall) begin
            valid_out_q      <= valid_out_d;
            result_q         <= result_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    branch_resolve_squash_counter #(
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .CNT_W       (CNT_W)
    ) u_squash_counter (
        .clock (clock),
        .reset (reset),
        .stall (stall),
        .load  (mispredict),
        .dec   (valid_in & busy),
        .busy  (busy)
    );

    assign valid_out      = valid_out_q;
    assign result         = result_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign squashing      = busy;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Scoreboard bench for branch_resolve. The driver computes the
//               expected stage-4 outputs from a behavioural model and queues
//               them; an independent monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic               clock;
    logic               reset;
    logic               stall;
    logic               valid_in;
    logic [INSTR_W-1:0] instr_type;
    logic [1:0]         cond_sel;
    logic               predict_taken;
    logic [31:0]        pc;
    logic [31:0]        imm;
    logic [3:0]         compare_async;
    logic [31:0]        eval_async;
    logic               valid_out;
    logic [31:0]        result;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               squashing;

    branch_resolve dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .valid_in       (valid_in),
        .instr_type     (instr_type),
        .cond_sel       (cond_sel),
        .predict_taken  (predict_taken),
        .pc             (pc),
        .imm            (imm),
        .compare_async  (compare_async),
        .eval_async     (eval_async),
        .valid_out      (valid_out),
        .result         (result),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .squashing      (squashing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        vo;
        logic [31:0] res;
        logic        rv;
        logic [31:0] rpc;
        logic        chk_rpc;
        logic        sq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the stage-4 outputs should read
    int          m_pending;   // wrong-path instructions still to drop
    logic        m_vo;
    logic [31:0] m_res;
    logic        m_rv;
    logic [31:0] m_rpc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the expected response
    task automatic drive(input logic rst, input logic st, input logic vin, input int cls,
                         input logic [1:0] cs, input logic pr, input logic [31:0] p,
                         input logic [31:0] im, input logic [3:0] cmp, input logic [31:0] ev);
        exp_t               e;
        logic [INSTR_W-1:0] oh;
        logic               is_live;
        logic               tk;
        logic [31:0]        fall_through;
        logic [31:0]        dest;
        @(negedge clock);
        oh            = '0;
        oh[cls]       = 1'b1;
        reset         = rst;
        stall         = st;
        valid_in      = vin;
        instr_type    = oh;
        cond_sel      = cs;
        predict_taken = pr;
        pc            = p;
        imm           = im;
        compare_async = cmp;
        eval_async    = ev;

        if (rst) begin
            m_pending = 0;
            m_vo      = 1'b0;
            m_res     = 32'h0;
            m_rv      = 1'b0;
            m_rpc     = 32'h0;
        end else if (!st) begin
            is_live      = vin && (m_pending == 0);
            fall_through = p + 32'd4;
            case (cls)
                DO_BRANCH:       tk = cmp[cs];
                DO_JAL, DO_JALR: tk = 1'b1;
                default:         tk = 1'b0;
            endcase
            if (cls == DO_JALR) dest = ev & 32'hFFFF_FFFE;
            else                dest = p + im;
            m_vo  = is_live;
            m_res = (cls == DO_JAL || cls == DO_JALR) ? fall_through : ev;
            if (is_live && (tk != pr)) begin
                m_rv      = 1'b1;
                m_rpc     = tk ? dest : fall_through;
                m_pending = 3;
            end else begin
                m_rv = 1'b0;
                if (vin && m_pending > 0) m_pending--;
            end
        end
        e.vo      = m_vo;
        e.res     = m_res;
        e.rv      = m_rv;
        e.rpc     = m_rpc;
        e.chk_rpc = m_rv | rst;
        e.sq      = (m_pending != 0);
        exp_q.push_back(e);
    endtask

    task automatic rnd(input logic rst, input logic st, input logic vin);
        int cls;
        logic pr;
        cls = int'($urandom_range(0, INSTR_W - 1));
        pr  = (cls == DO_JALR) ? 1'b0 : 1'($urandom_range(0, 1));
        drive(rst, st, vin, cls, 2'($urandom_range(0, 3)), pr, $urandom, $urandom,
              4'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic alu(input logic [31:0] ev);
        drive(1'b0, 1'b0, 1'b1, DO_ALU, 2'd0, 1'b0, 32'h1000, 32'h0, 4'h0, ev);
    endtask

    // Monitor: compare every presented output against the queued expectation
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("valid_out", {31'b0, valid_out}, {31'b0, mon_e.vo});
            chk("result", result, mon_e.res);
            chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, mon_e.rv});
            chk("squashing", {31'b0, squashing}, {31'b0, mon_e.sq});
            if (mon_e.chk_rpc) chk("redirect_pc", redirect_pc, mon_e.rpc);
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        m_pending     = 0;
        m_vo          = 1'b0;
        m_res         = 32'h0;
        m_rv          = 1'b0;
        m_rpc         = 32'h0;
        reset         = 1'b1;
        stall         = 1'b0;
        valid_in      = 1'b0;
        instr_type    = '0;
        cond_sel      = 2'd0;
        predict_taken = 1'b0;
        pc            = 32'h0;
        imm           = 32'h0;
        compare_async = 4'h0;
        eval_async    = 32'h0;

        // Reset with random inputs: everything reads zero
        rnd(1'b1, 1'b0, 1'b1);
        rnd(1'b1, 1'b1, 1'b1);

        // BEQ taken, predicted not taken -> redirect to 0x120, 3 squashed, 4th live
        drive(1'b0, 1'b0, 1'b1, DO_BRANCH, 2'(CMP_EQ), 1'b0, 32'h100, 32'h20, 4'b0001, 32'h0);
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b0, 1'b1);
        alu(32'h55);

        // BNE not taken, predicted taken -> redirect to 0x204
        drive(1'b0, 1'b0, 1'b1, DO_BRANCH, 2'(CMP_NE), 1'b1, 32'h200, 32'h80, 4'b0001, 32'h0);
        for (int i = 0; i < 3; i++) alu(32'(i));
        // BLT predicted taken and taken -> no redirect
        drive(1'b0, 1'b0, 1'b1, DO_BRANCH, 2'(CMP_LT), 1'b1, 32'h300, 32'h40, 4'b0100, 32'h7);

        // JALR -> redirect to 0x1234, link 0x44
        drive(1'b0, 1'b0, 1'b1, DO_JALR, 2'd0, 1'b0, 32'h40, 32'h5, 4'h0, 32'h1235);
        for (int i = 0; i < 3; i++) alu(32'hA0 + 32'(i));
        // JAL at top of address space, predicted taken -> link wraps to 0
        drive(1'b0, 1'b0, 1'b1, DO_JAL, 2'd0, 1'b1, 32'hFFFF_FFFC, 32'h10, 4'h0, 32'h9);

        // Mispredict then a 3-cycle stall: redirect held, then bubbles don't count
        drive(1'b0, 1'b0, 1'b1, DO_BRANCH, 2'(CMP_GE), 1'b0, 32'h500, 32'h8, 4'b1000, 32'h0);
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b1, 1'b1);
        rnd(1'b0, 1'b0, 1'b0);
        rnd(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) alu(32'hB0 + 32'(i));
        alu(32'hBB);

        // Reset mid-squash clears the counter; next instruction is live
        drive(1'b0, 1'b0, 1'b1, DO_BRANCH, 2'(CMP_EQ), 1'b0, 32'h600, 32'h10, 4'b0001, 32'h0);
        alu(32'hC0);
        rnd(1'b1, 1'b0, 1'b1);
        alu(32'hC1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rnd(1'($urandom_range(0, 99) < 2),
                1'($urandom_range(0, 99) < 15),
                1'($urandom_range(0, 99) < 80));
        end

        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
